// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the transmit FIR scheduler.
// FSM encoding, polyphase/flush geometry and the filler sample value.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int N_PHASES  = 4;
  localparam int N_FLUSH   = 6;
  localparam int FILL_DATA = 0;

endpackage

// File: rtl/fir_tick_gen.sv
// Programmable rate divider: one tick every div_q+1 cycles while run is high.
// clear restarts the count so the first tick lands div_q+1 cycles after run rises.
module fir_tick_gen #(
  parameter int NB_DIV = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [NB_DIV-1:0] div_q,
  input  logic              run,
  output logic              tick
);

  logic [NB_DIV-1:0] cnt;

  assign tick = run & ~clear & (cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + NB_DIV'(1);
    end
  end

endmodule

// File: rtl/fir_tx_scheduler.sv
// Strobe sequencer for the 4-phase polyphase TX FIR with a 1-entry symbol buffer.
// Optional underflow counter output enabled by FIR_SCHED_UNDERFLOW_CNT_EN.
module fir_tx_scheduler #(
  parameter int NB_DATA  = 8,
  parameter int NB_DIV   = 8,
  parameter int N_PHASES = fir_sched_pkg::N_PHASES,
  parameter int N_FLUSH  = fir_sched_pkg::N_FLUSH
`ifdef FIR_SCHED_UNDERFLOW_CNT_EN
  , parameter int NB_CNT = 16
`endif
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [NB_DIV-1:0]  i_div,
  input  logic               i_sym_valid,
  input  logic [NB_DATA-1:0] i_sym_data,
  output logic               o_sym_ready,
  output logic               o_fir_reset,
  output logic               o_fir_enable,
  output logic               o_fir_valid,
  output logic [NB_DATA-1:0] o_fir_data,
  output logic [1:0]         o_phase,
  output logic               o_busy,
  output logic               o_underflow
`ifdef FIR_SCHED_UNDERFLOW_CNT_EN
  , output logic [NB_CNT-1:0] o_underflow_cnt
`endif
);

  import fir_sched_pkg::*;

  localparam logic [1:0] LAST_PH = 2'(N_PHASES - 1);
  localparam int         NB_FL   = $clog2(N_FLUSH + 1);
  localparam logic [NB_FL-1:0] FL_MAX = NB_FL'(N_FLUSH);

  state_t              state;
  logic [NB_DIV-1:0]   div_q;
  logic                buf_full;
  logic [NB_DATA-1:0]  buf_data;
  logic                stop_pend;
  logic [NB_FL-1:0]    flush_cnt;
  logic                tick;
  logic                div_clear;
  logic                div_run;
  logic                xfer;
  logic [1:0]          ph_now;
  logic                strobe;
  logic                flush_done;

  // Handshake: a symbol moves when i_sym_valid and o_sym_ready are both high
  // at a rising clock edge; ready depends only on registered state, never on valid.
  assign o_sym_ready = ~buf_full & (state == START | state == RUN);
  assign xfer        = i_sym_valid & o_sym_ready;

  assign div_clear = (state == IDLE) & i_start & ~i_stop;
  assign div_run   = (state == RUN) | (state == FLUSH);

  // Phase the filter will hold while the next registered enable is visible.
  assign ph_now = o_fir_enable ? ((o_phase == LAST_PH) ? 2'd0 : o_phase + 2'd1) : o_phase;
  assign strobe = tick & (ph_now == 2'd0);

  // Leave FLUSH once the last enable after the final filler strobe wraps the phase.
  assign flush_done = (state == FLUSH) & o_fir_enable & (o_phase == LAST_PH) &
                      (flush_cnt == FL_MAX);

  fir_tick_gen #(.NB_DIV(NB_DIV)) u_tick (
    .clk   (clock),
    .rst_n (i_reset),
    .clear (div_clear),
    .div_q (div_q),
    .run   (div_run),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      div_q        <= '0;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      stop_pend    <= 1'b0;
      flush_cnt    <= '0;
      o_fir_reset  <= 1'b1;
      o_fir_enable <= 1'b0;
      o_fir_valid  <= 1'b0;
      o_fir_data   <= '0;
      o_phase      <= 2'd0;
      o_busy       <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      o_fir_enable <= 1'b0;
      o_fir_valid  <= 1'b0;
      o_underflow  <= 1'b0;
      o_phase      <= ph_now;
      if (xfer) begin
        buf_full <= 1'b1;
        buf_data <= i_sym_data;
      end
      case (state)
        IDLE: begin
          o_fir_reset <= 1'b1;
          o_busy      <= 1'b0;
          if (div_clear) begin
            state       <= START;
            div_q       <= i_div;
            o_phase     <= 2'd0;
            o_fir_reset <= 1'b0;
            o_busy      <= 1'b1;
            stop_pend   <= 1'b0;
            buf_full    <= 1'b0;
          end
        end
        START: begin
          if (i_stop) begin
            state       <= IDLE;
            o_fir_reset <= 1'b1;
            o_busy      <= 1'b0;
          end else if (buf_full) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (i_stop) stop_pend <= 1'b1;
          if (tick) o_fir_enable <= 1'b1;
          if (strobe) begin
            o_fir_valid <= 1'b1;
            // ready is low while full, so a consume never collides with a refill
            if (buf_full) begin
              o_fir_data <= buf_data;
              buf_full   <= 1'b0;
            end else begin
              o_underflow <= 1'b1;
            end
            if (stop_pend | i_stop) begin
              state     <= FLUSH;
              flush_cnt <= '0;
              buf_full  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          buf_full <= 1'b0;
          if (flush_done) begin
            state       <= IDLE;
            o_fir_reset <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            if (tick) o_fir_enable <= 1'b1;
            if (strobe && flush_cnt != FL_MAX) begin
              o_fir_valid <= 1'b1;
              o_fir_data  <= NB_DATA'(FILL_DATA);
              flush_cnt   <= flush_cnt + NB_FL'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef FIR_SCHED_UNDERFLOW_CNT_EN
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_underflow_cnt <= '0;
    end else if (div_clear) begin
      o_underflow_cnt <= '0;
    end else if (o_underflow && o_underflow_cnt != '1) begin
      o_underflow_cnt <= o_underflow_cnt + NB_CNT'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fir_tx_scheduler.sv
// Directed bench for fir_tx_scheduler: run, rate, underflow, stop/flush, corners, async reset.
// Define FIR_SCHED_UNDERFLOW_CNT_EN to also cover the underflow counter.
module tb_fir_tx_scheduler;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic [7:0] i_div = 8'd0;
  logic       i_sym_valid = 1'b0;
  logic [7:0] i_sym_data = 8'd0;
  logic       o_sym_ready;
  logic       o_fir_reset;
  logic       o_fir_enable;
  logic       o_fir_valid;
  logic [7:0] o_fir_data;
  logic [1:0] o_phase;
  logic       o_busy;
  logic       o_underflow;
`ifdef FIR_SCHED_UNDERFLOW_CNT_EN
  logic [15:0] o_underflow_cnt;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int c;

  always #5 clock = ~clock;

  fir_tx_scheduler dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_div        (i_div),
    .i_sym_valid  (i_sym_valid),
    .i_sym_data   (i_sym_data),
    .o_sym_ready  (o_sym_ready),
    .o_fir_reset  (o_fir_reset),
    .o_fir_enable (o_fir_enable),
    .o_fir_valid  (o_fir_valid),
    .o_fir_data   (o_fir_data),
    .o_phase      (o_phase),
    .o_busy       (o_busy),
    .o_underflow  (o_underflow)
`ifdef FIR_SCHED_UNDERFLOW_CNT_EN
    , .o_underflow_cnt (o_underflow_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fir_reset"}, 32'(o_fir_reset), 32'd1);
    check({tag, "_enable"}, 32'(o_fir_enable), 32'd0);
    check({tag, "_valid"}, 32'(o_fir_valid), 32'd0);
    check({tag, "_data"}, 32'(o_fir_data), 32'd0);
    check({tag, "_phase"}, 32'(o_phase), 32'd0);
    check({tag, "_ready"}, 32'(o_sym_ready), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_underflow"}, 32'(o_underflow), 32'd0);
  endtask

  // One clock; the source advances to the next symbol after each accepted transfer.
  task automatic step();
    logic xfer;
    xfer = i_sym_valid & o_sym_ready;
    @(negedge clock);
    if (xfer) i_sym_data = i_sym_data + 8'd1;
  endtask

  // which: 0 = enable, 1 = valid strobe. cyc = -1 when the budget expires.
  task automatic wait_for(input int which, input int budget, output int cyc);
    logic hit;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < budget) begin
      step();
      cyc++;
      hit = (which == 0) ? o_fir_enable : o_fir_valid;
    end
    if (!hit) cyc = -1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    i_reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs(tag);
    i_reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic start_run();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Basic run at full rate
    do_reset("rst0");
    i_div = 8'd0;
    i_sym_valid = 1'b1;
    i_sym_data = 8'hA1;
    start_run();
    check("basic_busy", 32'(o_busy), 32'd1);
    check("basic_fir_reset", 32'(o_fir_reset), 32'd0);
    for (int k = 0; k < 5; k++) begin
      wait_for(1, 8, c);
      check("basic_strobe_gap", 32'(c), (k == 0) ? 32'd3 : 32'd1);
      check("basic_data", 32'(o_fir_data), 32'(8'hA1 + k));
      check("basic_phase0", 32'(o_phase), 32'd0);
      check("basic_enable", 32'(o_fir_enable), 32'd1);
      check("basic_underflow", 32'(o_underflow), 32'd0);
      for (int j = 1; j < 4; j++) begin
        step();
        check("basic_en_cont", 32'(o_fir_enable), 32'd1);
        check("basic_no_valid", 32'(o_fir_valid), 32'd0);
        check("basic_phase", 32'(o_phase), 32'(j));
      end
    end

    // Stop mid-run: one consuming strobe, then six filler strobes
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("stop_last_valid", 32'(o_fir_valid), 32'd1);
    check("stop_last_data", 32'(o_fir_data), 32'hA6);
    check("flush_ready", 32'(o_sym_ready), 32'd0);
    for (int f = 0; f < 6; f++) begin
      wait_for(1, 8, c);
      check("flush_gap", 32'(c), 32'd4);
      check("flush_data", 32'(o_fir_data), 32'd0);
      check("flush_no_underflow", 32'(o_underflow), 32'd0);
      check("flush_busy", 32'(o_busy), 32'd1);
    end
    for (int j = 1; j < 4; j++) begin
      step();
      check("flush_tail_en", 32'(o_fir_enable), 32'd1);
      check("flush_tail_phase", 32'(o_phase), 32'(j));
    end
    step();
    check("flush_end_busy", 32'(o_busy), 32'd0);
    check("flush_end_fir_reset", 32'(o_fir_reset), 32'd1);
    check("flush_end_phase", 32'(o_phase), 32'd0);
    check("flush_end_enable", 32'(o_fir_enable), 32'd0);
    wait_for(0, 10, c);
    check("idle_no_enable", 32'(c), 32'hFFFF_FFFF);

    // Rate: divider setting 3
    do_reset("rst1");
    i_div = 8'd3;
    i_sym_valid = 1'b1;
    i_sym_data = 8'hB1;
    start_run();
    wait_for(0, 12, c);
    check("rate_first_en", 32'(c), 32'd6);
    check("rate_first_valid", 32'(o_fir_valid), 32'd1);
    check("rate_first_data", 32'(o_fir_data), 32'hB1);
    for (int j = 1; j < 4; j++) begin
      wait_for(0, 8, c);
      check("rate_en_period", 32'(c), 32'd4);
      check("rate_phase", 32'(o_phase), 32'(j));
      check("rate_no_valid", 32'(o_fir_valid), 32'd0);
    end
    wait_for(1, 8, c);
    check("rate_valid_gap", 32'(c), 32'd4);
    check("rate_data2", 32'(o_fir_data), 32'hB2);
    i_div = 8'd0;
    wait_for(1, 24, c);
    check("rate_valid_period", 32'(c), 32'd16);
    check("rate_data3", 32'(o_fir_data), 32'hB3);

    // Start/stop corners
    do_reset("rst2");
    i_div = 8'd0;
    i_sym_valid = 1'b0;
    i_start = 1'b1;
    i_stop = 1'b1;
    step();
    i_start = 1'b0;
    i_stop = 1'b0;
    check("startstop_busy", 32'(o_busy), 32'd0);
    check("startstop_fir_reset", 32'(o_fir_reset), 32'd1);
    start_run();
    check("start_busy", 32'(o_busy), 32'd1);
    check("start_fir_reset", 32'(o_fir_reset), 32'd0);
    check("start_ready", 32'(o_sym_ready), 32'd1);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("start_stop_busy", 32'(o_busy), 32'd0);
    check("start_stop_fir_reset", 32'(o_fir_reset), 32'd1);
    check("start_stop_ready", 32'(o_sym_ready), 32'd0);
    wait_for(0, 10, c);
    check("start_stop_no_enable", 32'(c), 32'hFFFF_FFFF);

    // Underflow: one symbol, then five strobes with nothing offered
    do_reset("rst3");
    i_div = 8'd0;
    i_sym_valid = 1'b0;
    start_run();
    i_sym_valid = 1'b1;
    i_sym_data = 8'hC1;
    step();
    i_sym_valid = 1'b0;
    wait_for(1, 8, c);
    check("uf_first_gap", 32'(c), 32'd2);
    check("uf_first_data", 32'(o_fir_data), 32'hC1);
    check("uf_first_no_uf", 32'(o_underflow), 32'd0);
    for (int u = 0; u < 5; u++) begin
      wait_for(1, 8, c);
      check("uf_gap", 32'(c), (u == 0) ? 32'd4 : 32'd3);
      check("uf_pulse", 32'(o_underflow), 32'd1);
      check("uf_data_held", 32'(o_fir_data), 32'hC1);
      step();
      check("uf_pulse_width", 32'(o_underflow), 32'd0);
    end
`ifdef FIR_SCHED_UNDERFLOW_CNT_EN
    check("uf_count", 32'(o_underflow_cnt), 32'd5);
`endif
    i_sym_valid = 1'b1;
    wait_for(1, 8, c);
    check("uf_recover_gap", 32'(c), 32'd3);
    check("uf_recover_data", 32'(o_fir_data), 32'hC2);
    check("uf_recover_no_uf", 32'(o_underflow), 32'd0);

    // Stop, enter flush, then async reset between clock edges
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    wait_for(1, 8, c);
    check("ar_last_gap", 32'(c), 32'd3);
    check("ar_last_data", 32'(o_fir_data), 32'hC3);
    wait_for(1, 8, c);
    check("ar_flush_gap", 32'(c), 32'd4);
    check("ar_flush_data", 32'(o_fir_data), 32'd0);
    step();
    step();
    #2;
    i_reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clock);
    check_reset_outputs("async_rst_hold");
    i_reset = 1'b1;
    i_sym_valid = 1'b1;
    i_sym_data = 8'hD1;
    @(negedge clock);
    start_run();
    wait_for(1, 8, c);
    check("ar_restart_gap", 32'(c), 32'd3);
    check("ar_restart_data", 32'(o_fir_data), 32'hD1);
    check("ar_restart_phase", 32'(o_phase), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
